// File: rtl/cache_ctrl_pkg.sv
// Shared types for the cache request controller.
package cache_ctrl_pkg;

  localparam int ADDR_W = 8;
  localparam int DATA_W = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    GAP   = 2'd2
  } state_t;

  // One queued CPU request; the top packs the same fields in this order.
  typedef struct packed {
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } req_t;

endpackage

// File: rtl/component_fifo.sv
// Small synchronous FIFO with count-based full/empty and a head-of-queue view.
module component_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] head,
  output logic             full,
  output logic             empty
);

  localparam int PW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    rd_ptr, wr_ptr;
  logic [CNT_W-1:0] count;
  logic             push_ok, pop_ok;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);
  assign push_ok = push & ~full;
  assign pop_ok  = pop & ~empty;
  assign head    = mem[rd_ptr];

  // Storage carries no reset; only entries below count are ever read.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= din;
  end

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= ptr_inc(wr_ptr);
      if (pop_ok)  rd_ptr <= ptr_inc(rd_ptr);
      case ({push_ok, pop_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/cache_request_ctrl.sv
// Initiator-side cache request controller: queues CPU requests, issues them one
// at a time as level-held re/we, retires on done or timeout, then idles a cycle.
module cache_request_ctrl
  import cache_ctrl_pkg::*;
#(
  parameter int ADDR_WIDTH     = 8,
  parameter int DATA_WIDTH     = 8,
  parameter int QUEUE_DEPTH    = 2,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  resp_valid,
  output logic                  resp_we,
  output logic [DATA_WIDTH-1:0] resp_rdata,
  output logic                  resp_timeout,
  output logic                  re,
  output logic                  we,
  output logic [ADDR_WIDTH-1:0] addr,
  output logic [DATA_WIDTH-1:0] wdata,
  input  logic [DATA_WIDTH-1:0] rdata,
  input  logic                  done
);

  localparam int REQ_W = 1 + ADDR_WIDTH + DATA_WIDTH;
  localparam int CW    = $clog2(TIMEOUT_CYCLES);
  localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT_CYCLES - 1);

  state_t            state, state_n;
  logic [CW-1:0]     cnt;
  logic              cur_we;
  logic              load, pop, retire_to;
  logic              q_full, q_empty, push;
  logic [REQ_W-1:0]  q_head;
  logic              head_we;
  logic [ADDR_WIDTH-1:0] head_addr;
  logic [DATA_WIDTH-1:0] head_wdata;

  // No bypass: a full queue refuses even on the cycle it pops.
  assign req_ready = ~q_full;
  assign push      = req_valid & req_ready;

  component_fifo #(
    .WIDTH (REQ_W),
    .DEPTH (QUEUE_DEPTH)
  ) u_req_q (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .din   ({req_we, req_addr, req_wdata}),
    .head  (q_head),
    .full  (q_full),
    .empty (q_empty)
  );

  assign {head_we, head_addr, head_wdata} = q_head;

  // Enables decode straight from state so an async reset drops them at once.
  assign re = (state == ISSUE) & ~cur_we;
  assign we = (state == ISSUE) &  cur_we;

  // Next-state and retire decisions; done takes priority over the timeout.
  always_comb begin
    state_n   = state;
    load      = 1'b0;
    pop       = 1'b0;
    retire_to = 1'b0;
    case (state)
      IDLE: begin
        if (!q_empty) begin
          state_n = ISSUE;
          load    = 1'b1;
        end
      end
      ISSUE: begin
        if (done) begin
          pop     = 1'b1;
          state_n = GAP;
        end else if (cnt == TO_LAST) begin
          pop       = 1'b1;
          retire_to = 1'b1;
          state_n   = GAP;
        end
      end
      GAP:     state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  // Timeout counter: cleared on issue, counts ISSUE cycles, stops on retire.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                        cnt <= '0;
    else if (load)                  cnt <= '0;
    else if (state == ISSUE && !pop) cnt <= cnt + 1'b1;
  end

  // Cache-side request registers; held between operations.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr   <= '0;
      wdata  <= '0;
      cur_we <= 1'b0;
    end else if (load) begin
      addr   <= head_addr;
      wdata  <= head_wdata;
      cur_we <= head_we;
    end
  end

  // Response registers: one-cycle pulse on the edge that retires a request.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      resp_valid   <= 1'b0;
      resp_we      <= 1'b0;
      resp_rdata   <= '0;
      resp_timeout <= 1'b0;
    end else begin
      resp_valid <= pop;
      if (pop) begin
        resp_we      <= cur_we;
        resp_timeout <= retire_to;
        resp_rdata   <= (done && !cur_we) ? rdata : '0;
      end
    end
  end

endmodule

// File: tb/tb_cache_request_ctrl.sv
// Randomized bench for cache_request_ctrl with an in-order transaction model
// and a latency-programmable cache model.
module tb_cache_request_ctrl;

  localparam int AW = 8, DW = 8, QD = 2, TO = 16, NEVER = 99;

  logic          clk = 1'b0, rst = 1'b1;
  logic          req_valid = 1'b0, req_ready, req_we = 1'b0;
  logic [AW-1:0] req_addr = '0;
  logic [DW-1:0] req_wdata = '0;
  logic          resp_valid, resp_we, resp_timeout;
  logic [DW-1:0] resp_rdata;
  logic          re, we;
  logic [AW-1:0] addr;
  logic [DW-1:0] wdata;
  logic [DW-1:0] rdata = '0;
  logic          done = 1'b0;

  cache_request_ctrl #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .QUEUE_DEPTH(QD), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_we(resp_we), .resp_rdata(resp_rdata),
    .resp_timeout(resp_timeout),
    .re(re), .we(we), .addr(addr), .wdata(wdata),
    .rdata(rdata), .done(done)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit       w;
    bit [7:0] a;
    bit [7:0] d;
    int       lat;   // cycles of re/we until done; > TO means never
    bit [7:0] er;
    bit       eto;
  } txn_t;

  txn_t     stim_q[$], iss_q[$], rsp_q[$];
  txn_t     cur;
  bit [7:0] cmem [256];
  bit [7:0] rmem [256];
  int       n_chk = 0, n_fail = 0;
  int       occ = 0, run = 0, gap = 100;
  bit       prev_act = 1'b0, throttle = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic push_req(input bit w, input bit [7:0] a, input bit [7:0] d, input int lat);
    txn_t t;
    t.w = w; t.a = a; t.d = d; t.lat = lat; t.er = 0; t.eto = 0;
    stim_q.push_back(t);
  endtask

  // One clock: observe outputs, run the cache model, then drive the CPU side.
  task automatic step();
    bit   act;
    txn_t t;
    int   exp_len;
    @(negedge clk);
    act = re | we;
    check("re_we_exclusive", 32'(re & we), 0);
    check("resp_valid", 32'(resp_valid), 32'(prev_act && !act));
    if (resp_valid) begin
      occ--;
      if (rsp_q.size() == 0) check("resp_unexpected", 1, 0);
      else begin
        t = rsp_q.pop_front();
        check("resp_we", 32'(resp_we), 32'(t.w));
        check("resp_rdata", 32'(resp_rdata), 32'(t.er));
        check("resp_timeout", 32'(resp_timeout), 32'(t.eto));
      end
    end
    check("req_ready", 32'(req_ready), 32'(occ < QD));

    if (act) begin
      if (run == 0) begin
        check("dead_cycles_ge2", 32'(gap >= 2), 1);
        if (iss_q.size() == 0) begin
          check("issue_unexpected", 1, 0);
          cur.lat = NEVER; cur.a = addr; cur.d = wdata; cur.w = we;
        end else cur = iss_q.pop_front();
      end
      run++;
      check("issue_addr", 32'(addr), 32'(cur.a));
      check("issue_wdata", 32'(wdata), 32'(cur.d));
      check("issue_type", 32'(we), 32'(cur.w));
      done = (run == cur.lat);
      if (done && re) rdata = cmem[addr];
      else            rdata = 8'($urandom);
      if (done && we) cmem[addr] = wdata;
    end else begin
      if (run > 0) begin
        exp_len = (cur.lat < TO) ? cur.lat : TO;
        check("issue_length", 32'(run), 32'(exp_len));
        run = 0;
        gap = 0;
      end
      gap++;
      done  = ($urandom_range(0, 3) == 0);   // spurious, must be ignored
      rdata = 8'($urandom);
    end
    prev_act = act;

    if (!rst && stim_q.size() != 0 && req_ready && (!throttle || $urandom_range(0, 3) != 0)) begin
      t = stim_q.pop_front();
      req_valid = 1'b1; req_we = t.w; req_addr = t.a; req_wdata = t.d;
      if (t.lat > TO) begin
        t.eto = 1; t.er = 0;
      end else begin
        t.eto = 0;
        if (t.w) begin rmem[t.a] = t.d; t.er = 0; end
        else t.er = rmem[t.a];
      end
      iss_q.push_back(t);
      rsp_q.push_back(t);
      occ++;
    end else begin
      req_valid = 1'b0;
      req_we    = 1'($urandom);
      req_addr  = 8'($urandom);
      req_wdata = 8'($urandom);
    end
  endtask

  task automatic drain();
    int k = 0;
    while ((stim_q.size() != 0 || rsp_q.size() != 0 || re || we) && k < 3000) begin
      step();
      k++;
    end
    check("drain_bound", 32'(k < 3000), 1);
    repeat (3) step();
  endtask

  initial begin
    int lats[7] = '{2, 3, 2, 3, 5, 16, NEVER};
    for (int i = 0; i < 256; i++) begin
      cmem[i] = 8'($urandom);
      rmem[i] = cmem[i];
    end
    cmem[8'h12] = 8'hA5; rmem[8'h12] = 8'hA5;

    // Reset state
    #1;
    check("rst_req_ready", 32'(req_ready), 1);
    check("rst_re", 32'(re), 0);
    check("rst_we", 32'(we), 0);
    check("rst_addr", 32'(addr), 0);
    check("rst_wdata", 32'(wdata), 0);
    check("rst_resp_valid", 32'(resp_valid), 0);
    check("rst_resp_rdata", 32'(resp_rdata), 0);
    check("rst_resp_flags", 32'({resp_we, resp_timeout}), 0);
    repeat (2) step();
    rst = 1'b0;
    repeat (3) step();

    // Read hit
    push_req(0, 8'h12, 8'h00, 2);
    drain();
    // Write miss then read hit of the same address
    push_req(1, 8'h20, 8'h3C, 3);
    push_req(0, 8'h20, 8'h00, 2);
    drain();
    // Overfill while the first request stalls
    push_req(0, 8'h30, 8'h01, 6);
    push_req(1, 8'h31, 8'h02, 2);
    push_req(0, 8'h31, 8'h03, 2);
    drain();
    // Timeout, then a normal request
    push_req(0, 8'h40, 8'h00, NEVER);
    push_req(1, 8'h41, 8'h77, 2);
    drain();
    // done on the final timeout cycle
    push_req(0, 8'h12, 8'h00, 16);
    drain();

    // Random traffic with address reuse
    throttle = 1'b1;
    for (int i = 0; i < 150; i++)
      push_req(1'($urandom), 8'($urandom_range(0, 15)), 8'($urandom), lats[$urandom_range(0, 6)]);
    drain();
    throttle = 1'b0;

    // Reset mid-ISSUE with the queue full
    push_req(0, 8'h50, 8'h00, NEVER);
    push_req(0, 8'h51, 8'h00, NEVER);
    push_req(1, 8'h52, 8'h99, NEVER);
    repeat (8) step();
    check("pre_rst_re", 32'(re), 1);
    check("pre_rst_full", 32'(req_ready), 0);
    #2 rst = 1'b1;
    #1;
    check("async_rst_re", 32'(re), 0);
    check("async_rst_we", 32'(we), 0);
    check("async_rst_ready", 32'(req_ready), 1);
    stim_q.delete(); iss_q.delete(); rsp_q.delete();
    occ = 0; run = 0; gap = 100; prev_act = 1'b0;
    req_valid = 1'b0;
    for (int i = 0; i < 256; i++) rmem[i] = cmem[i];
    repeat (3) step();
    rst = 1'b0;
    repeat (10) step();

    // Recovery after reset
    push_req(1, 8'h60, 8'h5A, 3);
    push_req(0, 8'h60, 8'h00, 2);
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
